// File: rtl/mem_arbiter_if.sv
// Purpose : bundles the request/response wires of the three requesters,
//           the memory-controller issue/complete port and the global
//           rdy/clear/io_buffer_full controls of mem_arbiter.
// Ports   : master = requester/controller side (environment), slave = arbiter.
interface mem_arbiter_if;
  logic        rdy;
  logic        clear;
  logic        io_buffer_full;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;

  logic        ld_req;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic        ld_done;
  logic [31:0] ld_data;

  logic        st_req;
  logic [31:0] st_addr;
  logic [1:0]  st_size;
  logic [31:0] st_data;
  logic        st_done;

  logic        mc_valid;
  logic        mc_we;
  logic [31:0] mc_addr;
  logic [2:0]  mc_len;
  logic [31:0] mc_wdata;
  logic        mc_done;
  logic [31:0] mc_rdata;

  modport master (
    output rdy, clear, io_buffer_full,
    output if_req, if_addr,
    output ld_req, ld_addr, ld_size, ld_signed,
    output st_req, st_addr, st_size, st_data,
    output mc_done, mc_rdata,
    input  if_done, if_data, ld_done, ld_data, st_done,
    input  mc_valid, mc_we, mc_addr, mc_len, mc_wdata
  );

  modport slave (
    input  rdy, clear, io_buffer_full,
    input  if_req, if_addr,
    input  ld_req, ld_addr, ld_size, ld_signed,
    input  st_req, st_addr, st_size, st_data,
    input  mc_done, mc_rdata,
    output if_done, if_data, ld_done, ld_data, st_done,
    output mc_valid, mc_we, mc_addr, mc_len, mc_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose : fixed-priority (store > load > fetch) scheduler of one shared memory
//           controller, with a fetch anti-starvation guard and flush squashing.
// Latency : grant -> mc_valid next cycle; done pulse one cycle after mc_done.
// Backpr. : one access outstanding; rdy low freezes everything; I/O stores wait
//           while io_buffer_full. Ports: clk, rst (sync, high), bus (slave).
module mem_arbiter #(
  parameter int          DATA_BURST_MAX = 4,
  parameter logic [31:0] IO_BASE        = 32'h30000
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int SW = $clog2(DATA_BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  typedef enum logic [1:0] {OWN_IF = 2'd0, OWN_LD = 2'd1, OWN_ST = 2'd2} owner_t;

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic          squash, squash_nxt;
  logic          grant;
  logic          st_elig, force_if;

  logic [31:0]   addr_q, wdata_q, rdata_q, if_data_q, ld_data_q;
  logic [2:0]    len_q;
  logic [1:0]    size_q;
  logic          we_q, signed_q, done_seen;
  logic          if_done_q, ld_done_q, st_done_q;

  logic [31:0]   g_addr, g_wdata, rdata_raw, ld_ext;
  logic [1:0]    g_size;
  logic [2:0]    g_len;
  logic          g_we, g_signed;

  assign st_elig  = bus.st_req && !((bus.st_addr >= IO_BASE) && bus.io_buffer_full);
  assign force_if = bus.if_req && (streak == SW'(DATA_BURST_MAX));

  // Next state, grant selection and streak/squash bookkeeping.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    streak_nxt = streak;
    squash_nxt = squash;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        squash_nxt = 1'b0;
        if (!bus.clear) begin
          if (force_if)        begin grant = 1'b1; owner_nxt = OWN_IF; end
          else if (st_elig)    begin grant = 1'b1; owner_nxt = OWN_ST; end
          else if (bus.ld_req) begin grant = 1'b1; owner_nxt = OWN_LD; end
          else if (bus.if_req) begin grant = 1'b1; owner_nxt = OWN_IF; end
        end
        if (grant) begin
          state_nxt = ISSUE;
          if (owner_nxt == OWN_IF || !bus.if_req) streak_nxt = '0;
          else if (streak != SW'(DATA_BURST_MAX)) streak_nxt = streak + 1'b1;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
        if (bus.clear && owner != OWN_ST) squash_nxt = 1'b1;
      end
      WAIT: begin
        if (bus.clear && owner != OWN_ST) squash_nxt = 1'b1;
        // A squashed read still drains from the controller, but reports nothing.
        if (bus.mc_done || done_seen) state_nxt = squash_nxt ? IDLE : RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Access parameters of the requester being granted.
  always_comb begin
    g_we     = 1'b0;
    g_addr   = bus.if_addr;
    g_size   = 2'd2;
    g_wdata  = wdata_q;
    g_signed = 1'b0;
    case (owner_nxt)
      OWN_LD: begin
        g_addr   = bus.ld_addr;
        g_size   = bus.ld_size;
        g_signed = bus.ld_signed;
      end
      OWN_ST: begin
        g_we    = 1'b1;
        g_addr  = bus.st_addr;
        g_size  = bus.st_size;
        g_wdata = bus.st_data;
      end
      default: ;
    endcase
    case (g_size)
      2'd0:    g_len = 3'd1;
      2'd1:    g_len = 3'd2;
      default: g_len = 3'd4;
    endcase
  end

  // A completion seen while rdy was low is parked in rdata_q/done_seen.
  assign rdata_raw = bus.mc_done ? bus.mc_rdata : rdata_q;

  always_comb begin
    ld_ext = rdata_raw;
    case (size_q)
      2'd0:    ld_ext = {{24{signed_q & rdata_raw[7]}},  rdata_raw[7:0]};
      2'd1:    ld_ext = {{16{signed_q & rdata_raw[15]}}, rdata_raw[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      streak    <= '0;
      squash    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      len_q     <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      signed_q  <= 1'b0;
      done_seen <= 1'b0;
      if_data_q <= '0;
      ld_data_q <= '0;
      if_done_q <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
    end else begin
      if (state == WAIT && bus.mc_done) begin
        done_seen <= 1'b1;
        rdata_q   <= bus.mc_rdata;
      end
      if (bus.rdy) begin
        state     <= state_nxt;
        owner     <= owner_nxt;
        streak    <= streak_nxt;
        squash    <= squash_nxt;
        if_done_q <= 1'b0;
        ld_done_q <= 1'b0;
        st_done_q <= 1'b0;
        if (grant) begin
          addr_q   <= g_addr;
          len_q    <= g_len;
          we_q     <= g_we;
          wdata_q  <= g_wdata;
          size_q   <= g_size;
          signed_q <= g_signed;
        end
        if (state == WAIT && state_nxt != WAIT) begin
          done_seen <= 1'b0;
          if (state_nxt == RESP) begin
            case (owner)
              OWN_IF:  begin if_done_q <= 1'b1; if_data_q <= rdata_raw; end
              OWN_LD:  begin ld_done_q <= 1'b1; ld_data_q <= ld_ext;    end
              default: st_done_q <= 1'b1;
            endcase
          end
        end
      end
    end
  end

  assign bus.mc_valid = (state == ISSUE) && bus.rdy;
  assign bus.mc_we    = we_q;
  assign bus.mc_addr  = addr_q;
  assign bus.mc_len   = len_q;
  assign bus.mc_wdata = wdata_q;
  // A flush landing on the response cycle suppresses read completions only.
  assign bus.if_done  = if_done_q & ~bus.clear;
  assign bus.ld_done  = ld_done_q & ~bus.clear;
  assign bus.st_done  = st_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.ld_data  = ld_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.DATA_BURST_MAX(4), .IO_BASE(32'h30000)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [1:0] K_IF = 2'd0, K_LD = 2'd1, K_ST = 2'd2;

  typedef struct packed {logic we; logic [31:0] addr; logic [2:0] len; logic [31:0] wdata;} iss_t;
  typedef struct packed {logic [1:0] kind; logic [31:0] data;} dn_t;

  iss_t iss_q[$];
  dn_t  dn_q[$];
  int checks = 0, failures = 0;
  int if_cnt = 0, ld_cnt = 0, st_cnt = 0, mc_delay = 1;
  int n_if_done = 0, n_ld_done = 0, n_st_done = 0;
  logic [31:0] mem_img [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [2:0] len);
    if (len == 3'd1) return 32'h0000_00FF;
    if (len == 3'd2) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [2:0] len_of(input logic [1:0] size);
    if (size == 2'd0) return 3'd1;
    if (size == 2'd1) return 3'd2;
    return 3'd4;
  endfunction

  function automatic logic [31:0] rd_val(input logic [31:0] a, input logic [2:0] len);
    logic [31:0] raw;
    raw = mem_img.exists(a) ? mem_img[a] : (a ^ 32'hA5A5_0000);
    return raw & mask_of(len);
  endfunction

  task automatic exp_issue(input logic we, input logic [31:0] a, input logic [2:0] l, input logic [31:0] wd);
    iss_t e;
    e.we = we; e.addr = a; e.len = l; e.wdata = wd;
    iss_q.push_back(e);
  endtask

  task automatic exp_done(input logic [1:0] k, input logic [31:0] d);
    dn_t e;
    e.kind = k; e.data = d;
    dn_q.push_back(e);
  endtask

  task automatic exp_fetch(input logic [31:0] a);
    exp_issue(1'b0, a, 3'd4, 32'h0);
    exp_done(K_IF, rd_val(a, 3'd4));
  endtask

  task automatic exp_load(input logic [31:0] a, input logic [1:0] size, input logic [31:0] d);
    exp_issue(1'b0, a, len_of(size), 32'h0);
    exp_done(K_LD, d);
  endtask

  task automatic exp_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] wd);
    exp_issue(1'b1, a, len_of(size), wd);
    exp_done(K_ST, 32'h0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((iss_q.size() != 0 || dn_q.size() != 0 || if_cnt > 0 || ld_cnt > 0 || st_cnt > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, 32'(iss_q.size() + dn_q.size() + if_cnt + ld_cnt + st_cnt), 32'd0);
    cyc(2);
  endtask

  // Memory-controller model: answers each issue after mc_delay cycles.
  initial begin : mc_model
    iss_t e;
    logic [31:0] a, wd;
    logic [2:0] l;
    logic we;
    bus.mc_done = 1'b0;
    bus.mc_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mc_valid === 1'b1) begin
        a = bus.mc_addr; l = bus.mc_len; we = bus.mc_we; wd = bus.mc_wdata;
        chk("issue_expected", 32'(iss_q.size() > 0), 32'd1);
        if (iss_q.size() > 0) begin
          e = iss_q.pop_front();
          chk("issue_we", 32'(we), 32'(e.we));
          chk("issue_addr", a, e.addr);
          chk("issue_len", 32'(l), 32'(e.len));
          if (e.we) chk("issue_wdata", wd & mask_of(e.len), e.wdata & mask_of(e.len));
        end
        for (int k = 0; k < mc_delay; k++) @(negedge clk);
        bus.mc_done = 1'b1;
        bus.mc_rdata = we ? 32'h0 : rd_val(a, l);
        @(negedge clk);
        bus.mc_done = 1'b0;
        bus.mc_rdata = '0;
      end
    end
  end

  // Completion monitor: pops the scoreboard and retires the requester.
  initial begin : done_mon
    dn_t e;
    logic [1:0] k;
    logic [31:0] d;
    logic hit;
    forever begin
      @(negedge clk);
      hit = 1'b1;
      k = K_IF;
      d = '0;
      if (bus.if_done === 1'b1) begin
        k = K_IF; d = bus.if_data; n_if_done++;
        if (if_cnt > 0) if_cnt--;
        bus.if_req = (if_cnt > 0);
      end else if (bus.ld_done === 1'b1) begin
        k = K_LD; d = bus.ld_data; n_ld_done++;
        if (ld_cnt > 0) ld_cnt--;
        bus.ld_req = (ld_cnt > 0);
      end else if (bus.st_done === 1'b1) begin
        k = K_ST; n_st_done++;
        if (st_cnt > 0) st_cnt--;
        bus.st_req = (st_cnt > 0);
      end else begin
        hit = 1'b0;
      end
      if (hit) begin
        chk("done_expected", 32'(dn_q.size() > 0), 32'd1);
        if (dn_q.size() > 0) begin
          e = dn_q.pop_front();
          chk("done_kind", 32'(k), 32'(e.kind));
          if (k != K_ST) chk("done_data", d, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {logic [31:0] addr; logic [1:0] size; logic sgn; logic [31:0] exp;} ldv_t;
  ldv_t ldv[5];

  initial begin : main
    int n0, n;
    rst = 1'b1;
    bus.rdy = 1'b1; bus.clear = 1'b0; bus.io_buffer_full = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_size = '0; bus.ld_signed = 1'b0;
    bus.st_req = 1'b0; bus.st_addr = '0; bus.st_size = '0; bus.st_data = '0;
    mem_img[32'h100] = 32'hDEADBEEF;
    mem_img[32'h400] = 32'h0000_0080;
    mem_img[32'h404] = 32'h0000_F00D;
    mem_img[32'h408] = 32'h8765_4321;
    cyc(3);

    // Reset state
    chk("rst_dones", {29'b0, bus.if_done, bus.ld_done, bus.st_done}, 32'd0);
    chk("rst_mc_valid_we", {30'b0, bus.mc_valid, bus.mc_we}, 32'd0);
    chk("rst_mc_addr", bus.mc_addr, 32'd0);
    chk("rst_mc_len", 32'(bus.mc_len), 32'd0);
    chk("rst_mc_wdata", bus.mc_wdata, 32'd0);
    chk("rst_if_data", bus.if_data, 32'd0);
    chk("rst_ld_data", bus.ld_data, 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    chk("rst_streak_squash", {28'b0, 3'(dut.streak), dut.squash}, 32'd0);
    rst = 1'b0;
    cyc(2);

    // Single fetch, controller answers two cycles after mc_valid
    mc_delay = 2;
    n0 = n_if_done;
    bus.if_addr = 32'h100;
    exp_fetch(32'h100);
    if_cnt = 1; bus.if_req = 1'b1;
    drain("single_fetch", 50);
    chk("single_fetch_once", 32'(n_if_done - n0), 32'd1);
    chk("single_fetch_data", bus.if_data, 32'hDEADBEEF);
    chk("single_fetch_idle", 32'(dut.state), 32'd0);

    // Simultaneous requests: ST, LD, IF
    mc_delay = 1;
    bus.st_addr = 32'h200; bus.st_size = 2'd2; bus.st_data = 32'h11223344;
    bus.ld_addr = 32'h300; bus.ld_size = 2'd2; bus.ld_signed = 1'b0;
    bus.if_addr = 32'h104;
    exp_store(32'h200, 2'd2, 32'h11223344);
    exp_load(32'h300, 2'd2, rd_val(32'h300, 3'd4));
    exp_fetch(32'h104);
    st_cnt = 1; ld_cnt = 1; if_cnt = 1;
    bus.st_req = 1'b1; bus.ld_req = 1'b1; bus.if_req = 1'b1;
    drain("simultaneous", 80);

    // Load extension table
    ldv[0] = '{32'h400, 2'd0, 1'b1, 32'hFFFF_FF80};
    ldv[1] = '{32'h400, 2'd0, 1'b0, 32'h0000_0080};
    ldv[2] = '{32'h404, 2'd1, 1'b0, 32'h0000_F00D};
    ldv[3] = '{32'h404, 2'd1, 1'b1, 32'hFFFF_F00D};
    ldv[4] = '{32'h408, 2'd3, 1'b0, 32'h8765_4321};
    for (int i = 0; i < 5; i++) begin
      bus.ld_addr = ldv[i].addr; bus.ld_size = ldv[i].size; bus.ld_signed = ldv[i].sgn;
      exp_load(ldv[i].addr, ldv[i].size, ldv[i].exp);
      ld_cnt = 1; bus.ld_req = 1'b1;
      drain("load_ext", 40);
      chk("load_ext_hold", bus.ld_data, ldv[i].exp);
    end

    // Starvation guard: 4 loads then 1 fetch, twice
    bus.ld_addr = 32'h300; bus.ld_size = 2'd2; bus.ld_signed = 1'b0;
    bus.if_addr = 32'h104;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) exp_load(32'h300, 2'd2, rd_val(32'h300, 3'd4));
      exp_fetch(32'h104);
    end
    ld_cnt = 8; if_cnt = 2;
    bus.ld_req = 1'b1; bus.if_req = 1'b1;
    drain("starvation", 300);

    // Flush during WAIT of a fetch: no if_done, IDLE right after mc_done
    mc_delay = 4;
    n0 = n_if_done;
    bus.if_addr = 32'h500;
    exp_issue(1'b0, 32'h500, 3'd4, 32'h0);
    if_cnt = 1; bus.if_req = 1'b1;
    cyc(2);
    chk("flush_if_in_wait", 32'(dut.state), 32'd2);
    bus.clear = 1'b1; if_cnt = 0; bus.if_req = 1'b0;
    cyc(1);
    bus.clear = 1'b0;
    cyc(3);
    chk("flush_if_idle", 32'(dut.state), 32'd0);
    drain("flush_if", 40);
    chk("flush_if_no_done", 32'(n_if_done - n0), 32'd0);

    // Flush during WAIT of a store: store still completes
    n0 = n_st_done;
    bus.st_addr = 32'h600; bus.st_size = 2'd1; bus.st_data = 32'hCAFE_BEEF;
    exp_store(32'h600, 2'd1, 32'hCAFE_BEEF);
    st_cnt = 1; bus.st_req = 1'b1;
    cyc(2);
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    drain("flush_st", 40);
    chk("flush_st_done", 32'(n_st_done - n0), 32'd1);

    // I/O hold-off: load goes first, store waits for io_buffer_full to drop
    mc_delay = 1;
    bus.io_buffer_full = 1'b1;
    bus.st_addr = 32'h30000; bus.st_size = 2'd0; bus.st_data = 32'h0000_0041;
    bus.ld_addr = 32'h700; bus.ld_size = 2'd2; bus.ld_signed = 1'b0;
    exp_load(32'h700, 2'd2, rd_val(32'h700, 3'd4));
    exp_store(32'h30000, 2'd0, 32'h0000_0041);
    st_cnt = 1; ld_cnt = 1;
    bus.st_req = 1'b1; bus.ld_req = 1'b1;
    n = 0;
    while (ld_cnt > 0 && n < 40) begin @(negedge clk); n++; end
    chk("io_load_done", 32'(ld_cnt), 32'd0);
    cyc(4);
    chk("io_store_held_state", 32'(dut.state), 32'd0);
    chk("io_store_held_cnt", 32'(st_cnt), 32'd1);
    bus.io_buffer_full = 1'b0;
    cyc(1);
    chk("io_store_issue_next", {30'b0, bus.mc_valid, bus.mc_we}, 32'd3);
    drain("io_store", 40);
    // Just below IO_BASE the full flag does not matter
    bus.io_buffer_full = 1'b1;
    bus.st_addr = 32'h2FFFC; bus.st_size = 2'd2; bus.st_data = 32'h5566_7788;
    exp_store(32'h2FFFC, 2'd2, 32'h5566_7788);
    st_cnt = 1; bus.st_req = 1'b1;
    drain("below_io", 40);
    bus.io_buffer_full = 1'b0;

    // rdy low for 3 cycles mid-WAIT; mc_done arrives while frozen
    mc_delay = 3;
    bus.if_addr = 32'h800;
    exp_fetch(32'h800);
    if_cnt = 1; bus.if_req = 1'b1;
    cyc(2);
    bus.rdy = 1'b0;
    cyc(1);
    chk("rdy_hold_state", 32'(dut.state), 32'd2);
    chk("rdy_hold_mc_valid", 32'(bus.mc_valid), 32'd0);
    cyc(2);
    chk("rdy_hold_state_after_done", 32'(dut.state), 32'd2);
    chk("rdy_hold_no_done", 32'(bus.if_done), 32'd0);
    bus.rdy = 1'b1;
    cyc(1);
    chk("rdy_resume_done", 32'(bus.if_done), 32'd1);
    chk("rdy_resume_data", bus.if_data, rd_val(32'h800, 3'd4));
    drain("rdy", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
